// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI parser (master) and the voice allocator (slave).
interface voice_allocator_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_on;
  logic [6:0]  in_note;
  logic [23:0] in_freq;
  logic [6:0]  in_vel;

  modport master (
    output in_valid,
    output in_on,
    output in_note,
    output in_freq,
    output in_vel,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_on,
    input  in_note,
    input  in_freq,
    input  in_vel,
    output in_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger, else free slot, else steal the oldest sounding voice.
// One event is scanned one voice per cycle, then committed in a single edge.
module voice_allocator #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned AGE_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   panic,
  voice_allocator_if.slave       bus,
  output logic [24*VOICES-1:0]   voice_freq,
  output logic [7*VOICES-1:0]    voice_vel,
  output logic [VOICES-1:0]      voice_gate,
  output logic [4:0]             active_count
);

  localparam int unsigned IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned FREQ_W = 24;
  localparam int unsigned NOTE_W = 7;
  localparam int unsigned VEL_W  = 7;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                in_ready_q, in_ready_d;

  // Latched event
  logic                ev_on_q, ev_on_d;
  logic [NOTE_W-1:0]   ev_note_q, ev_note_d;
  logic [FREQ_W-1:0]   ev_freq_q, ev_freq_d;
  logic [VEL_W-1:0]    ev_vel_q, ev_vel_d;

  // Scan results
  logic                match_vld_q, match_vld_d;
  logic [IDX_W-1:0]    match_idx_q, match_idx_d;
  logic                free_vld_q, free_vld_d;
  logic [IDX_W-1:0]    free_idx_q, free_idx_d;
  logic                old_vld_q, old_vld_d;
  logic [IDX_W-1:0]    old_idx_q, old_idx_d;
  logic [AGE_W-1:0]    old_age_q, old_age_d;

  // Per-voice state
  logic [NOTE_W-1:0]   note_q [VOICES];
  logic [NOTE_W-1:0]   note_d [VOICES];
  logic [FREQ_W-1:0]   freq_q [VOICES];
  logic [FREQ_W-1:0]   freq_d [VOICES];
  logic [VEL_W-1:0]    vel_q  [VOICES];
  logic [VEL_W-1:0]    vel_d  [VOICES];
  logic [AGE_W-1:0]    age_q  [VOICES];
  logic [AGE_W-1:0]    age_d  [VOICES];
  logic [VOICES-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    tgt;

  // Next-state, scan bookkeeping and commit of the latched event
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    ev_on_d     = ev_on_q;
    ev_note_d   = ev_note_q;
    ev_freq_d   = ev_freq_q;
    ev_vel_d    = ev_vel_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    gate_d      = gate_q;
    tgt         = '0;
    for (int i = 0; i < VOICES; i++) begin
      note_d[i] = note_q[i];
      freq_d[i] = freq_q[i];
      vel_d[i]  = vel_q[i];
      age_d[i]  = age_q[i];
    end

    if (panic) begin
      // All-notes-off: pitch and note are kept for release tails, event dropped
      state_d    = ST_IDLE;
      idx_d      = '0;
      in_ready_d = 1'b1;
      gate_d     = '0;
      for (int i = 0; i < VOICES; i++) begin
        vel_d[i] = '0;
        age_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          in_ready_d = 1'b1;
          if (bus.in_valid && in_ready_q) begin
            ev_on_d     = bus.in_on && (bus.in_vel != '0);
            ev_note_d   = bus.in_note;
            ev_freq_d   = bus.in_freq;
            ev_vel_d    = bus.in_vel;
            match_vld_d = 1'b0;
            match_idx_d = '0;
            free_vld_d  = 1'b0;
            free_idx_d  = '0;
            old_vld_d   = 1'b0;
            old_idx_d   = '0;
            old_age_d   = '0;
            idx_d       = '0;
            in_ready_d  = 1'b0;
            state_d     = ST_SCAN;
          end
        end

        ST_SCAN: begin
          in_ready_d = 1'b0;
          if (!match_vld_q && gate_q[idx_q] && (note_q[idx_q] == ev_note_q)) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          if (!free_vld_q && !gate_q[idx_q]) begin
            free_vld_d = 1'b1;
            free_idx_d = idx_q;
          end
          // Strict compare keeps the lowest index on age ties
          if (gate_q[idx_q] && (!old_vld_q || (age_q[idx_q] > old_age_q))) begin
            old_vld_d = 1'b1;
            old_idx_d = idx_q;
            old_age_d = age_q[idx_q];
          end
          if (idx_q == IDX_W'(VOICES - 1)) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end

        ST_COMMIT: begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          if (ev_on_q) begin
            if (match_vld_q) begin
              tgt = match_idx_q;
            end else if (free_vld_q) begin
              tgt = free_idx_q;
            end else begin
              tgt = old_idx_q;
            end
            for (int i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == tgt) begin
                note_d[i] = ev_note_q;
                freq_d[i] = ev_freq_q;
                vel_d[i]  = ev_vel_q;
                age_d[i]  = '0;
                gate_d[i] = 1'b1;
              end else if (gate_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
                age_d[i] = age_q[i] + AGE_W'(1);
              end
            end
          end else if (match_vld_q) begin
            gate_d[match_idx_q] = 1'b0;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b0;
        end
      endcase
    end

    cnt_d = '0;
    for (int i = 0; i < VOICES; i++) begin
      cnt_d = cnt_d + CNT_W'(gate_d[i]);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_freq_q   <= '0;
      ev_vel_q    <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      gate_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        freq_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      ev_on_q     <= ev_on_d;
      ev_note_q   <= ev_note_d;
      ev_freq_q   <= ev_freq_d;
      ev_vel_q    <= ev_vel_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      gate_q      <= gate_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= note_d[i];
        freq_q[i] <= freq_d[i];
        vel_q[i]  <= vel_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  // Flatten per-voice registers onto the oscillator-facing buses
  always_comb begin
    voice_freq = '0;
    voice_vel  = '0;
    for (int i = 0; i < VOICES; i++) begin
      voice_freq[FREQ_W*i +: FREQ_W] = freq_q[i];
      voice_vel[VEL_W*i +: VEL_W]    = vel_q[i];
    end
  end

  assign voice_gate   = gate_q;
  assign active_count = cnt_q;
  assign bus.in_ready = in_ready_q;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the MIDI parser and the tone-generator bank. It accepts one note event at a time (note number, frequency word, velocity, on/off) and assigns it to one of VOICES generator slots. Reassignment order is: retrigger of an already-sounding note, then a free slot, then stealing the oldest slot. It drives per-voice frequency, velocity and gate registers that the oscillators read directly.

## Interface
- VOICES, 4: number of generator slots, 2..16.
- AGE_W, 8: width of the per-voice saturating age counter.
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- panic  in  1  all-notes-off; synchronous, evaluated every cycle.
- in_valid  in  1  note event present.
- in_ready  out  1  the allocator can accept an event.
- in_on  in  1  1 = note-on, 0 = note-off.
- in_note  in  7  MIDI note number.
- in_freq  in  24  frequency word (Hz*1000), same format as the parser output.
- in_vel  in  7  velocity; 0 together with in_on=1 is treated as a note-off.
- voice_freq  out  24*VOICES  per-voice frequency; voice i occupies bits [24i+23:24i].
- voice_vel  out  7*VOICES  per-voice velocity.
- voice_gate  out  VOICES  per-voice gate (1 = sounding).
- active_count  out  5  number of set bits in voice_gate.

## Operation
- Internal state per voice: note[6:0], freq, vel, gate, age[AGE_W-1:0].
- The FSM has three states: IDLE, SCAN and COMMIT.
  - IDLE: in_ready=1. If in_valid=1, latch the event, clear the scan results, and go to SCAN with idx=0.
  - SCAN: evaluate one voice per cycle (idx 0..VOICES-1). Record:
    - the first voice with gate=1 and a matching note;
    - the first voice with gate=0;
    - the voice with gate=1 and the largest age. Ties go to the lower index, so the comparison is strict >.
  - After idx=VOICES-1, go to COMMIT.
  - COMMIT: apply the event and go to IDLE.
- Note-on (in_on=1 and in_vel≠0), target chosen in this priority:
  - matching voice (retrigger);
  - else lowest free voice;
  - else oldest active voice (steal).
- Note-on writes the target's note, freq, vel, sets gate=1 and age=0. Every other voice with gate=1 increments age, saturating at 2^AGE_W-1. Voices with gate=0 keep their age.
- Note-off (in_on=0, or in_vel=0): if there is a matching voice, clear its gate. Its freq, vel and note are retained so release tails keep their pitch. If there is no match, nothing changes. The event still consumes the full scan.
- active_count is registered and updated on the same edge as voice_gate.
- panic=1: at the next edge, all gates, vels and ages go to 0 and the FSM goes to IDLE. Freq and note are retained. Any in-flight event is discarded, and an event presented in the same cycle is not accepted.
- Priority on a clock edge: reset_n=0, then panic, then FSM.

## Timing
- Reset (reset_n=0 at an edge): FSM=IDLE; voice_freq=0, voice_vel=0, voice_gate=0, active_count=0; all ages=0.
  - in_ready=0 while reset_n=0.
  - in_ready=1 from the first edge with reset_n=1.
- in_ready is registered. It is 1 only in IDLE and not during panic.
- An event is accepted at edge E where in_valid=1 and in_ready=1.
  - in_ready=0 from E.
  - Edges E+1..E+VOICES perform the scan.
  - Edge E+VOICES+1 performs COMMIT. Outputs update and in_ready=1 at that same edge.
- Latency is VOICES+1 cycles. Maximum throughput is one event per VOICES+2 cycles; for VOICES=4, one event per 6 cycles.
- in_valid while in_ready=0 is ignored. The producer must hold the event or drop it; there is no queue.
- Inputs other than in_valid are sampled only at the accept edge.
- Reset or panic asserted during SCAN/COMMIT aborts the event with no partial update.

## Test plan
- Reset, then note-on note 60, freq 261625, vel 100 → after 5 cycles: voice0 freq=261625, vel=100, gate=1; active_count=1; in_ready is 0 for exactly 5 cycles.
- Note-ons for notes 60, 62, 64, 65, then note 67 (VOICES=4) → 67 steals voice0 (age 3, the oldest). voice0 freq=391995; gates=4'b1111.
- Note-on 60 vel 100, then note-on 60 vel 50 → same voice0 retriggered: vel=50, age=0; active_count stays 1.
- Note-on 60, then note-on 60 vel 0 → gate0=0, freq0 still 261625; a note-off for unheld note 70 changes nothing.
- Four voices active, pulse panic during an event's SCAN → next edge: all gates=0, vel=0, active_count=0, in_ready=1; the aborted event is never committed.
- in_valid held high continuously with changing in_note → exactly one event accepted per 6 cycles; notes presented while in_ready=0 are never allocated.
